// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, single-outstanding imem req/ack, 2-entry instruction buffer
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d, head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d, tail_pc_q, tail_pc_d;

  logic        pop, push, flush, slot_free;
  logic [1:0]  cnt_after_pop, cnt_after_push;
  logic [31:0] target;

  assign pop            = (count_q != 2'd0) && !stall;
  assign cnt_after_pop  = count_q - {1'b0, pop};
  assign cnt_after_push = count_q + 2'd1 - {1'b0, pop};
  assign slot_free      = cnt_after_pop < 2'(DEPTH);
  assign target         = redirect_pc & ~32'h3;

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = (state_q == DRAIN) ? hold_q : pc_q;
  assign instr       = head_instr_q;
  assign instr_pc    = head_pc_q;
  assign instr_valid = (count_q != 2'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    flush   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_en) begin
          pc_d  = target;
          flush = 1'b1;
        end else if (slot_free) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (redirect_en) begin
          pc_d  = target;
          flush = 1'b1;
          // Without an ack the old request is still owed; keep presenting its address.
          if (!imem_ack) begin
            hold_d  = pc_q;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
          if (cnt_after_push >= 2'(DEPTH)) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_en) begin
          pc_d  = target;
          flush = 1'b1;
        end
        if (imem_ack) state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && pop) begin
      if (count_q == 2'd1) begin
        head_instr_d = imem_rdata;
        head_pc_d    = pc_q;
      end else begin
        head_instr_d = tail_instr_q;
        head_pc_d    = tail_pc_q;
        tail_instr_d = imem_rdata;
        tail_pc_d    = pc_q;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_instr_d = imem_rdata;
        head_pc_d    = pc_q;
      end else begin
        tail_instr_d = imem_rdata;
        tail_pc_d    = pc_q;
      end
      count_d = count_q + 2'd1;
    end else if (pop) begin
      head_instr_d = tail_instr_q;
      head_pc_d    = tail_pc_q;
      count_d      = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      hold_q       <= 32'd0;
      count_q      <= 2'd0;
      head_instr_q <= 32'd0;
      head_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized bench for instr_fetch with an in-order delivery model
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_en, stall, force_ack;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;

  int total = 0;
  int bad   = 0;
  int mem_delay = 0;
  int wait_cnt  = 0;
  int n_deliv   = 0;

  logic [31:0] exp_pc;
  logic        prev_wait;
  logic [31:0] prev_addr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  // Memory answers mem_delay cycles into a request with address-derived data.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = force_ack | (imem_req & (wait_cnt >= mem_delay));
  assign imem_rdata = imem_addr ^ SALT;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Delivered stream must be consecutive words from the last redirect target (or RESET_PC).
  task automatic monitor();
    if (rst) begin
      exp_pc    = RESET_PC;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("req_hold", {31'd0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (redirect_en) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && !stall) begin
        chk("deliv_pc", instr_pc, exp_pc);
        chk("deliv_instr", instr, exp_pc ^ SALT);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_exp [4];
    logic [31:0] got_f [4];
    logic [31:0] got_d [4];
    int na, nd, n;

    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 32'd0; stall = 1'b0; force_ack = 1'b0;
    exp_pc = RESET_PC; prev_wait = 1'b0; prev_addr = 32'd0;

    // Zero-wait streaming from reset
    mem_delay = 0;
    do_reset();
    chk("c0_req", {31'd0, imem_req}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("stream_req", {31'd0, imem_req}, 32'd1);
      chk("stream_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        chk("stream_valid", {31'd0, instr_valid}, 32'd1);
        chk("stream_pc", instr_pc, 32'(4 * (k - 1)));
        chk("stream_instr", instr, 32'(4 * (k - 1)) ^ SALT);
      end
      step();
    end
    chk("stream_pc_last", instr_pc, 32'd12);

    // Stall for 5 cycles: two words buffered, then request drops
    stall = 1'b1;
    do_reset();
    step();
    chk("stall_c1_addr", imem_addr, 32'd0);
    step();
    chk("stall_c2_addr", imem_addr, 32'd4);
    chk("stall_c2_pc", instr_pc, 32'd0);
    step();
    chk("stall_req_drop", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_head_pc", instr_pc, 32'd0);
    chk("stall_head_instr", instr, SALT);
    step();
    chk("stall_req_drop2", {31'd0, imem_req}, 32'd0);
    chk("stall_head_pc2", instr_pc, 32'd0);
    stall = 1'b0;
    chk("unstall_pc0", instr_pc, 32'd0);
    step();
    chk("unstall_pc4", instr_pc, 32'd4);
    step();
    chk("unstall_pc8", instr_pc, 32'd8);

    // Delayed memory; redirect while the fetch of 0x8 is outstanding
    mem_delay = 3;
    do_reset();
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 40) begin step(); n++; end
    chk("wait_req8", {31'd0, imem_req && imem_addr == 32'h8}, 32'd1);
    step();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0100;
    chk("redir_addr8", imem_addr, 32'h8);
    chk("redir_noack", {31'd0, imem_ack}, 32'd0);
    step();
    redirect_en = 1'b0;
    n = 0;
    while (!imem_ack && n < 10) begin
      chk("drain_addr", imem_addr, 32'h8);
      chk("drain_valid", {31'd0, instr_valid}, 32'd0);
      step(); n++;
    end
    chk("drain_ack_seen", {31'd0, imem_ack}, 32'd1);
    chk("drain_ack_addr", imem_addr, 32'h8);
    step();
    chk("after_drain_req", {31'd0, imem_req}, 32'd1);
    chk("after_drain_addr", imem_addr, 32'h100);
    n = 0;
    while (!instr_valid && n < 10) begin step(); n++; end
    chk("t100_valid", {31'd0, instr_valid}, 32'd1);
    chk("t100_pc", instr_pc, 32'h100);
    chk("t100_instr", instr, 32'h100 ^ SALT);
    stall = 1'b1;

    // Redirect coincident with ack: word dropped, FIFO flushed
    n = 0;
    while (!imem_ack && n < 10) begin step(); n++; end
    chk("ackredir_ack", {31'd0, imem_ack}, 32'd1);
    chk("ackredir_pre_valid", {31'd0, instr_valid}, 32'd1);
    redirect_en = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect_en = 1'b0;
    chk("ackredir_flush", {31'd0, instr_valid}, 32'd0);
    chk("ackredir_req", {31'd0, imem_req}, 32'd1);
    chk("ackredir_addr", imem_addr, 32'h200);
    stall = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin step(); n++; end
    chk("t200_pc", instr_pc, 32'h200);

    // Address wrap at the top of the space
    mem_delay = 0;
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_en = 1'b0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;
    na = 0; nd = 0;
    for (int i = 0; i < 20 && (na < 4 || nd < 4); i++) begin
      if (imem_req && imem_ack && na < 4) begin got_f[na] = imem_addr; na++; end
      if (instr_valid && !stall && nd < 4) begin got_d[nd] = instr_pc; nd++; end
      step();
    end
    chk("wrap_nfetch", 32'(na), 32'd4);
    chk("wrap_ndeliv", 32'(nd), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < na) chk("wrap_fetch", got_f[i], wrap_exp[i]);
      if (i < nd) chk("wrap_deliv", got_d[i], wrap_exp[i]);
    end

    // Reset while draining; a late ack must be ignored
    mem_delay = 3;
    step();
    chk("pre_drain_req", {31'd0, imem_req}, 32'd1);
    chk("pre_drain_noack", {31'd0, imem_ack}, 32'd0);
    redirect_en = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect_en = 1'b0;
    chk("drain_req_out", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstdrain_req", {31'd0, imem_req}, 32'd0);
    chk("rstdrain_valid", {31'd0, instr_valid}, 32'd0);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RESET_PC);
    chk("late_ack_dropped", {31'd0, instr_valid}, 32'd0);
    n = 0;
    while (!instr_valid && n < 10) begin step(); n++; end
    chk("restart_pc", instr_pc, RESET_PC);
    chk("restart_instr", instr, RESET_PC ^ SALT);

    // Randomized traffic against the delivery model
    n_deliv = 0;
    for (int i = 0; i < 800; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      if (!redirect_en && $urandom_range(0, 99) < 6) begin
        redirect_en = 1'b1;
        redirect_pc = $urandom;
      end else begin
        redirect_en = 1'b0;
      end
      mem_delay = $urandom_range(0, 3);
      step();
    end
    redirect_en = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rand_progress", {31'd0, n_deliv > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder/control unit.
- Keeps the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a 2-entry FIFO and presents {instr, instr_pc, instr_valid} to decode.
- Handles branch/jump redirects by flushing the FIFO and discarding any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value fetched first after reset.
- DEPTH, 2, instruction buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word address of the request, bits [1:0] always 0
- imem_ack  in  1  memory returns imem_rdata this cycle for the current request
- imem_rdata  in  32  instruction word, valid only when imem_ack=1
- redirect_en  in  1  taken branch/jump from execute, single-cycle pulse
- redirect_pc  in  32  new fetch target
- stall  in  1  decode cannot accept the head instruction this cycle
- instr  out  32  FIFO head instruction
- instr_pc  out  32  address of instr
- instr_valid  out  1  FIFO non-empty

Behaviour:
- Reset, sync, priority over all other inputs:
  - pc=RESET_PC, state=IDLE, count=0.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - A reset during an outstanding request abandons it; an ack arriving later is ignored.
- pop = instr_valid & ~stall. The head is removed at the clock edge and the next entry becomes head.
- imem_req = (state != IDLE). imem_addr = pc in BUSY and hold_addr in DRAIN. Both stay stable until ack (memory protocol).
- Free slot: (count - pop) < 2.
- States:
  - IDLE:
    - redirect_en -> pc<=redirect_pc & ~3, flush, stay IDLE.
    - Else, if a slot is free -> BUSY.
  - BUSY:
    - redirect_en & ~imem_ack -> hold_addr<=pc, pc<=redirect_pc & ~3, flush, DRAIN.
    - redirect_en & imem_ack -> data discarded, pc<=redirect_pc & ~3, flush, BUSY. The new address goes out next cycle.
    - imem_ack only -> push {imem_rdata, pc}, pc<=pc+4. Stay BUSY if count_next<2, else IDLE.
    - No ack -> hold.
  - DRAIN:
    - imem_ack -> discard data, BUSY at pc.
    - redirect_en -> pc<=redirect_pc & ~3, flush, stay DRAIN.
    - Both in the same cycle -> discard data, take the new pc, go to BUSY.
- Flush sets count=0 and instr_valid=0 in the next cycle. It overrides any push or pop in the same cycle.
- Simultaneous push and pop with count=2 is impossible: no request is issued without a free slot. With count=1, count stays 1.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Low redirect bits are silently cleared.
- Latency:
  - First imem_req is in the cycle after rst deasserts.
  - An ack at edge N gives instr_valid=1 after edge N.
  - With zero-wait memory (ack in the same cycle as req) and no stall, throughput is 1 instruction/cycle.
  - A redirect in IDLE or BUSY+ack puts the redirect target on imem_addr one cycle later.
- Only one request is outstanding at a time.

Test Plan:
- Reset release with RESET_PC=0, zero-wait memory returning addr-derived data (rdata = addr ^ 32'hA5A5_0000), stall=0:
  - Consecutive imem_addr = 0, 4, 8, 12.
  - instr_valid is high continuously from the 2nd cycle after reset.
  - instr_pc increments by 4 each cycle.
- stall=1 held for 5 cycles:
  - Exactly 2 words are buffered (pc 0, 4), then imem_req drops. instr stays at the pc=0 word.
  - After stall=0: words for pc 0, 4, 8 emerge in order with no loss or duplication.
- Memory with 3-cycle ack delay; redirect_en to 32'h0000_0100 one cycle after a request to 0x8 is issued:
  - imem_addr stays 0x8 until ack and that data is dropped.
  - Next request is to 0x100; instr_valid stays 0 until the 0x100 word arrives.
- redirect_en to 32'h0000_0203 in the same cycle as imem_ack:
  - Acked word is not pushed; the FIFO is flushed.
  - Next imem_addr = 0x200.
- Redirect to 32'hFFFF_FFF8, zero-wait memory:
  - Fetch sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004, with matching instr_pc.
- rst asserted while in DRAIN with a request outstanding:
  - Next cycle: imem_req=0, instr_valid=0.
  - A late imem_ack is ignored.
  - Fetch restarts at RESET_PC.
